// File: rtl/rand_history_buf.sv
// Circular history of the last DEPTH random values with a browse key stepping back through them.
// Optional RAND_HIST_TIMEOUT_EN: browsing returns to the newest entry after TIMEOUT_CYC idle cycles.
`timescale 1ns/1ps
module rand_history_buf #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_browse,
  input  logic                     i_clear,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH)-1:0] o_index,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [1:0]               o_state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LIVE   = 2'd1,
    ST_BROWSE = 2'd2
  } state_t;

  state_t           r_state, w_state_next;
  logic [AW-1:0]    r_wr_ptr, w_wr_ptr_next;
  logic [AW-1:0]    r_index, w_index_next;
  logic [AW:0]      r_count, w_count_next;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_write;
  logic [AW:0]      w_index_inc;
  logic [AW-1:0]    w_rd_addr;
  logic             w_timeout;

`ifdef RAND_HIST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] r_idle;

  assign w_timeout = (r_state == ST_BROWSE) && (r_idle == IDLE_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || (w_state_next != ST_BROWSE) || i_browse || i_valid || i_clear)
      r_idle <= '0;
    else
      r_idle <= r_idle + TW'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_index_inc = {1'b0, r_index} + (AW+1)'(1);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_next  = r_state;
    w_index_next  = r_index;
    w_wr_ptr_next = r_wr_ptr;
    w_count_next  = r_count;
    w_write       = 1'b0;
    if (i_clear) begin
      w_state_next  = ST_EMPTY;
      w_index_next  = '0;
      w_wr_ptr_next = '0;
      w_count_next  = '0;
    end else if (i_valid) begin
      w_write       = 1'b1;
      w_wr_ptr_next = r_wr_ptr + AW'(1);
      w_count_next  = (r_count == DEPTH_CNT) ? r_count : r_count + (AW+1)'(1);
      w_state_next  = ST_LIVE;
      w_index_next  = '0;
    end else if (i_browse) begin
      case (r_state)
        ST_LIVE: begin
          if (r_count >= (AW+1)'(2)) begin
            w_state_next = ST_BROWSE;
            w_index_next = AW'(1);
          end
        end
        ST_BROWSE: begin
          if (w_index_inc == r_count) begin
            w_state_next = ST_LIVE;
            w_index_next = '0;
          end else begin
            w_index_next = w_index_inc[AW-1:0];
          end
        end
        default: ;
      endcase
    end else if (w_timeout) begin
      w_state_next = ST_LIVE;
      w_index_next = '0;
    end
  end

  assign w_rd_addr = w_wr_ptr_next - AW'(1) - w_index_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_EMPTY;
      r_wr_ptr <= '0;
      r_index  <= '0;
      r_count  <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_index  <= w_index_next;
      r_count  <= w_count_next;
      // A write always selects index 0, i.e. the slot being written, so forward i_data.
      if (w_state_next == ST_EMPTY)
        r_data <= '0;
      else if (w_write)
        r_data <= i_data;
      else
        r_data <= r_mem[w_rd_addr];
    end
  end

  // NOTE: the storage array has no reset; count and pointer define which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (w_write)
      r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_data;
  assign o_index = r_index;
  assign o_count = r_count;
  assign o_full  = (r_count == DEPTH_CNT);
  assign o_empty = (r_count == '0);
  assign o_state = r_state;

endmodule

// File: tb/tb_rand_history_buf.sv
// Scoreboard bench for rand_history_buf (DEPTH=8, WIDTH=4, TIMEOUT_CYC=16 when the timeout build is used).
`timescale 1ns/1ps
module tb_rand_history_buf;

  localparam int EMPTY = 0, LIVE = 1, BROWSE = 2;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_valid = 1'b0, i_browse = 1'b0, i_clear = 1'b0;
  logic [3:0] i_data = '0;
  logic [3:0] o_data;
  logic [2:0] o_index;
  logic [3:0] o_count;
  logic       o_full, o_empty;
  logic [1:0] o_state;

  typedef struct {
    int due;
    int data;
    int idx;
    int cnt;
    int st;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  rand_history_buf #(.DEPTH(8), .WIDTH(4), .TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_browse(i_browse), .i_clear(i_clear), .o_data(o_data), .o_index(o_index),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_state(o_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are compared on the falling edge of the cycle each expectation is due.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check("due_cycle", e.due, cyc);
      check("o_data", 32'(o_data), e.data);
      check("o_index", 32'(o_index), e.idx);
      check("o_count", 32'(o_count), e.cnt);
      check("o_full", 32'(o_full), (e.cnt == 8) ? 1 : 0);
      check("o_empty", 32'(o_empty), (e.cnt == 0) ? 1 : 0);
      check("o_state", 32'(o_state), e.st);
    end
  end

  task automatic step(input logic rst, input logic valid, input int data,
                      input logic browse, input logic clear,
                      input int e_data, input int e_idx, input int e_cnt, input int e_st);
    exp_t e;
    @(negedge clk);
    i_rst    = rst;
    i_valid  = valid;
    i_data   = 4'(data);
    i_browse = browse;
    i_clear  = clear;
    e.due  = cyc + 1;
    e.data = e_data;
    e.idx  = e_idx;
    e.cnt  = e_cnt;
    e.st   = e_st;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset held two cycles, then idle and an ignored browse
    step(1, 0, 0, 0, 0, 0, 0, 0, EMPTY);
    step(1, 0, 0, 0, 0, 0, 0, 0, EMPTY);
    step(0, 0, 0, 0, 0, 0, 0, 0, EMPTY);
    step(0, 0, 0, 1, 0, 0, 0, 0, EMPTY);
    // capture 3, 7, 9; browse with a single entry is ignored
    step(0, 1, 3, 0, 0, 3, 0, 1, LIVE);
    step(0, 0, 0, 1, 0, 3, 0, 1, LIVE);
    step(0, 1, 7, 0, 0, 7, 0, 2, LIVE);
    step(0, 1, 9, 0, 0, 9, 0, 3, LIVE);
    // browse older and wrap back to newest
    step(0, 0, 0, 1, 0, 7, 1, 3, BROWSE);
    step(0, 0, 0, 1, 0, 3, 2, 3, BROWSE);
    step(0, 0, 0, 1, 0, 9, 0, 3, LIVE);
    // valid and browse together in BROWSE: write wins, back to LIVE
    step(0, 0, 0, 1, 0, 7, 1, 3, BROWSE);
    step(0, 0, 0, 1, 0, 3, 2, 3, BROWSE);
    step(0, 1, 5, 1, 0, 5, 0, 4, LIVE);
    // ten writes 0..9 fill and overwrite; history becomes 2..9
    for (int v = 0; v < 10; v++)
      step(0, 1, v, 0, 0, v, 0, (5 + v > 8) ? 8 : 5 + v, LIVE);
    for (int k = 1; k < 8; k++)
      step(0, 0, 0, 1, 0, 9 - k, k, 8, BROWSE);
    step(0, 0, 0, 1, 0, 9, 0, 8, LIVE);
    step(0, 0, 0, 1, 0, 8, 1, 8, BROWSE);
    // clear beats a simultaneous valid; 6 must not be stored
    step(0, 1, 6, 0, 1, 0, 0, 0, EMPTY);
    step(0, 0, 0, 1, 0, 0, 0, 0, EMPTY);
    step(0, 1, 1, 0, 0, 1, 0, 1, LIVE);
    step(0, 1, 4, 0, 0, 4, 0, 2, LIVE);
    step(0, 0, 0, 1, 0, 1, 1, 2, BROWSE);
    // idle stretch in BROWSE
    for (int k = 1; k <= 20; k++) begin
`ifdef RAND_HIST_TIMEOUT_EN
      if (k < 16) step(0, 0, 0, 0, 0, 1, 1, 2, BROWSE);
      else        step(0, 0, 0, 0, 0, 4, 0, 2, LIVE);
`else
      step(0, 0, 0, 0, 0, 1, 1, 2, BROWSE);
`endif
    end
    step(0, 0, 0, 0, 1, 0, 0, 0, EMPTY);
    @(negedge clk);
    i_clear = 1'b0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
